fifo_umbral: RTL and testbench

//  Single-channel synchronous FIFO that reports its occupancy back to the flow-control FSM.
//  It consumes the FSM's latched thresholds (umbral_empty/umbral_full) and produces:
//   - empty, which feeds one bit of the FSM's FIFO_empties vector;
//   - almost_empty / almost_full watermarks for upstream pause and downstream request.
//  One instance per channel; a bank of them forms the datapath the FSM supervises.

---
 rtl/fifo_pkg.sv | 45 ++++
 rtl/fifo_umbral_mem_dp.sv | 54 +++++
 rtl/fifo_umbral.sv | 159 +++++++++++++++
 tb/tb_fifo_umbral.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the flow-controlled FIFO bank and its supervising
//   FSM, so that both sides agree on default sizes and state encodings.
//
//   Contents:
//     FIFO_DATA_W / FIFO_DEPTH / FIFO_ADDR_W / FIFO_CNT_W
//                    default payload width, entry count, pointer width and
//                    occupancy/threshold width
//     fc_state_e     flow-control FSM state encoding
//     fifo_flags_t   registered occupancy flags of one channel
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int FIFO_DATA_W = 6;
   localparam int FIFO_DEPTH  = 8;
   localparam int FIFO_ADDR_W = 3;
   localparam int FIFO_CNT_W  = 5;

   // Flow-control FSM states. The FSM latches umbral_empty/umbral_full while
   // in FC_INIT and holds them stable afterwards.
   typedef enum logic [2:0] {
      FC_IDLE  = 3'd0,
      FC_INIT  = 3'd1,
      FC_RUN   = 3'd2,
      FC_PAUSE = 3'd3,
      FC_DRAIN = 3'd4
   } fc_state_e;

   // Occupancy flags, all derived from the post-update count.
   typedef struct packed {
      logic empty;
      logic full;
      logic almost_empty;
      logic almost_full;
   } fifo_flags_t;

   localparam fifo_flags_t FIFO_FLAGS_RST = '{
      empty:        1'b1,
      full:         1'b0,
      almost_empty: 1'b1,
      almost_full:  1'b0
   };

endpackage : fifo_pkg

// File: rtl/fifo_umbral_mem_dp.sv
// -----------------------------------------------------------------------------
// mem_dp
//   DEPTH x DATA_W storage with one write port and one registered read port.
//   The array itself is never reset; only the read register is cleared.
//
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   synchronous active-high reset (read register only)
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     re     in   read enable; rdata updates on the same edge
//     raddr  in   read address
//     rdata  out  registered read data, holds when re is low
// -----------------------------------------------------------------------------
module mem_dp
   import fifo_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W,
   parameter int DEPTH  = FIFO_DEPTH,
   parameter int ADDR_W = FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // A read and a write to the same address on one edge returns the old
   // word, which is what a pop at full with a simultaneous push needs.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule : mem_dp

// File: rtl/fifo_umbral.sv
// -----------------------------------------------------------------------------
// fifo_umbral
//   Single-channel synchronous FIFO reporting occupancy to the flow-control
//   FSM: empty feeds the FSM's FIFO_empties vector, almost_empty/almost_full
//   are watermarks against the FSM's latched thresholds.
//
//   Ports:
//     clk, rst       clock (rising) and synchronous active-high reset
//     push, data_in  write request and data, captured on the same edge
//     pop            read request; data_out/valid_out follow one edge later
//     umbral_empty   almost-empty threshold (clamped to DEPTH)
//     umbral_full    almost-full threshold (clamped to DEPTH)
//     data_out       registered read data, holds when valid_out is low
//     valid_out      one-cycle strobe per accepted pop
//     empty, full    count == 0 / count == DEPTH
//     almost_empty   count <= umbral_empty
//     almost_full    count >= umbral_full
//     count          occupancy
//     err_overflow   sticky, a push was dropped
//     err_underflow  sticky, a pop was dropped
// -----------------------------------------------------------------------------
module fifo_umbral
   import fifo_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W,
   parameter int DEPTH  = FIFO_DEPTH,
   parameter int ADDR_W = FIFO_ADDR_W,
   parameter int CNT_W  = FIFO_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] data_in,
   input  logic              pop,
   input  logic [CNT_W-1:0]  umbral_empty,
   input  logic [CNT_W-1:0]  umbral_full,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic [CNT_W-1:0]  count,
   output logic              err_overflow,
   output logic              err_underflow
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;
   fifo_flags_t       flags_q,  flags_d;
   logic              valid_q,  valid_d;
   logic              err_ovf_q, err_ovf_d;
   logic              err_unf_q, err_unf_d;

   logic              push_acc;
   logic              pop_acc;
   logic [CNT_W-1:0]  thr_empty;
   logic [CNT_W-1:0]  thr_full;

   // Acceptance is decided from the registered flags. At full a pop is
   // always accepted (full implies non-empty), which frees the slot the
   // push needs. At empty the pop is dropped but the push still goes in.
   always_comb begin
      pop_acc  = pop && !flags_q.empty;
      push_acc = push && (!flags_q.full || pop);
   end

   // Thresholds above DEPTH behave as DEPTH.
   always_comb begin
      thr_empty = (umbral_empty > DEPTH_C) ? DEPTH_C : umbral_empty;
      thr_full  = (umbral_full  > DEPTH_C) ? DEPTH_C : umbral_full;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push_acc) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop_acc) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end

      if (push_acc && !pop_acc) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_acc && !push_acc) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Flags are computed from count_d so they land on the same edge as the
   // count they describe. Threshold inputs are sampled every edge, so a
   // threshold change shows up at the next edge even when idle.
   always_comb begin
      flags_d              = FIFO_FLAGS_RST;
      flags_d.empty        = (count_d == '0);
      flags_d.full         = (count_d == DEPTH_C);
      flags_d.almost_empty = (count_d <= thr_empty);
      flags_d.almost_full  = (count_d >= thr_full);
   end

   always_comb begin
      valid_d   = pop_acc;
      err_ovf_d = err_ovf_q | (push && !push_acc);
      err_unf_d = err_unf_q | (pop && !pop_acc);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         flags_q   <= FIFO_FLAGS_RST;
         valid_q   <= 1'b0;
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         flags_q   <= flags_d;
         valid_q   <= valid_d;
         err_ovf_q <= err_ovf_d;
         err_unf_q <= err_unf_d;
      end
   end

   // Writes and reads are suppressed during reset so a push or pop in the
   // reset cycle has no effect.
   mem_dp #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (push_acc && !rst),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .re    (pop_acc && !rst),
      .raddr (rd_ptr_q),
      .rdata (data_out)
   );

   assign valid_out     = valid_q;
   assign empty         = flags_q.empty;
   assign full          = flags_q.full;
   assign almost_empty  = flags_q.almost_empty;
   assign almost_full   = flags_q.almost_full;
   assign count         = count_q;
   assign err_overflow  = err_ovf_q;
   assign err_underflow = err_unf_q;

endmodule : fifo_umbral

// File: tb/tb_fifo_umbral.sv
// -----------------------------------------------------------------------------
// tb_fifo_umbral
//   Directed self-checking bench for fifo_umbral. Inputs change on the
//   falling edge; outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_umbral;

   logic       clk = 1'b0;
   logic       rst;
   logic       push;
   logic [5:0] data_in;
   logic       pop;
   logic [4:0] umbral_empty;
   logic [4:0] umbral_full;
   logic [5:0] data_out;
   logic       valid_out;
   logic       empty;
   logic       full;
   logic       almost_empty;
   logic       almost_full;
   logic [4:0] count;
   logic       err_overflow;
   logic       err_underflow;

   int checks   = 0;
   int failures = 0;

   logic [5:0] exp_q[$];

   always #5 clk = ~clk;

   fifo_umbral dut (
      .clk           (clk),
      .rst           (rst),
      .push          (push),
      .data_in       (data_in),
      .pop           (pop),
      .umbral_empty  (umbral_empty),
      .umbral_full   (umbral_full),
      .data_out      (data_out),
      .valid_out     (valid_out),
      .empty         (empty),
      .full          (full),
      .almost_empty  (almost_empty),
      .almost_full   (almost_full),
      .count         (count),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle with the given request pattern.
   task automatic cyc(input logic p, input logic [5:0] d, input logic q);
      @(negedge clk);
      push    = p;
      data_in = d;
      pop     = q;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      push = 1'b0;
      pop  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       pop_ok;
      logic       push_ok;
      logic       p;
      logic       q;
      logic [5:0] exp_d;

      rst          = 1'b1;
      push         = 1'b0;
      pop          = 1'b0;
      data_in      = '0;
      umbral_empty = 5'd2;
      umbral_full  = 5'd6;

      // ---- 1. reset ---------------------------------------------------------
      do_reset();
      cyc(0, 6'h00, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_aempty", almost_empty, 1);
      chk("rst_afull", almost_full, 0);
      chk("rst_count", count, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_dout", data_out, 0);
      chk("rst_ovf", err_overflow, 0);
      chk("rst_unf", err_underflow, 0);

      // ---- 2. fill then drain -----------------------------------------------
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 6'(i), 0);
         chk("fill_count", count, i);
         chk("fill_empty", empty, 0);
         chk("fill_full", full, (i == 8));
      end
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 6'h00, 1);
         chk("drain_valid", valid_out, 1);
         chk("drain_data", data_out, i);
         chk("drain_count", count, 8 - i);
      end
      chk("drain_empty", empty, 1);
      cyc(0, 6'h00, 0);
      chk("idle_valid", valid_out, 0);
      chk("idle_hold", data_out, 6'h08);

      // ---- 3. watermarks, thresholds 2 / 6 ----------------------------------
      for (int i = 1; i <= 7; i++) begin
         cyc(1, 6'(8 + i), 0);
         chk("wm_aempty", almost_empty, (i <= 2));
         chk("wm_afull", almost_full, (i >= 6));
      end
      for (int i = 1; i <= 7; i++) begin
         cyc(0, 6'h00, 1);
         chk("wm_data", data_out, 8 + i);
         chk("wm_aempty_dn", almost_empty, ((7 - i) <= 2));
         chk("wm_afull_dn", almost_full, ((7 - i) >= 6));
      end

      // ---- threshold clamping -----------------------------------------------
      umbral_empty = 5'd31;
      umbral_full  = 5'd0;
      cyc(0, 6'h00, 0);
      chk("clamp_aempty0", almost_empty, 1);
      chk("clamp_afull0", almost_full, 1);
      cyc(1, 6'h15, 0);
      chk("clamp_aempty1", almost_empty, 1);
      chk("clamp_afull1", almost_full, 1);
      umbral_full = 5'd31;
      cyc(0, 6'h00, 0);
      chk("clamp_afull_hi", almost_full, 0);
      cyc(0, 6'h00, 1);
      chk("clamp_data", data_out, 6'h15);
      umbral_empty = 5'd2;
      umbral_full  = 5'd6;
      cyc(0, 6'h00, 0);
      chk("restore_aempty", almost_empty, 1);
      chk("restore_afull", almost_full, 0);

      // ---- 4. simultaneous push+pop -----------------------------------------
      for (int i = 0; i < 8; i++) cyc(1, 6'(16 + i), 0);
      chk("sim_full", full, 1);
      cyc(1, 6'h18, 1);
      chk("sim_full_count", count, 8);
      chk("sim_full_flag", full, 1);
      chk("sim_full_ovf", err_overflow, 0);
      chk("sim_full_valid", valid_out, 1);
      chk("sim_full_data", data_out, 6'h10);
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 6'h00, 1);
         chk("sim_drain_data", data_out, 16 + i);
      end
      chk("sim_drain_empty", empty, 1);
      cyc(1, 6'h20, 1);
      chk("sim_empty_count", count, 1);
      chk("sim_empty_unf", err_underflow, 1);
      chk("sim_empty_valid", valid_out, 0);
      chk("sim_empty_flag", empty, 0);
      chk("sim_empty_hold", data_out, 6'h18);
      cyc(0, 6'h00, 1);
      chk("sim_empty_data", data_out, 6'h20);
      chk("sim_empty_cnt0", count, 0);

      // ---- 5. overflow / underflow ------------------------------------------
      do_reset();
      cyc(0, 6'h00, 0);
      chk("err_clr_ovf", err_overflow, 0);
      chk("err_clr_unf", err_underflow, 0);
      for (int i = 0; i < 8; i++) cyc(1, 6'(48 + i), 0);
      cyc(1, 6'h3f, 0);
      chk("ovf_count", count, 8);
      chk("ovf_flag", err_overflow, 1);
      chk("ovf_unf", err_underflow, 0);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 6'h00, 1);
         chk("ovf_data", data_out, 48 + i);
      end
      cyc(0, 6'h00, 1);
      chk("unf_flag", err_underflow, 1);
      chk("unf_valid", valid_out, 0);
      chk("unf_count", count, 0);
      chk("unf_empty", empty, 1);
      cyc(0, 6'h00, 0);
      cyc(0, 6'h00, 0);
      chk("sticky_ovf", err_overflow, 1);
      chk("sticky_unf", err_underflow, 1);
      do_reset();
      cyc(0, 6'h00, 0);
      chk("rst2_ovf", err_overflow, 0);
      chk("rst2_unf", err_underflow, 0);

      // ---- 6. interleaved passes with pointer wrap --------------------------
      for (int i = 0; i < 20; i++) begin
         p       = ((i % 3) != 2);
         q       = ((i % 2) == 1);
         pop_ok  = q && (exp_q.size() > 0);
         push_ok = p && ((exp_q.size() < 8) || pop_ok);
         exp_d   = 6'h00;
         if (pop_ok) exp_d = exp_q.pop_front();
         if (push_ok) exp_q.push_back(6'(32 + i));
         cyc(p, 6'(32 + i), q);
         chk("mix_count", count, exp_q.size());
         chk("mix_valid", valid_out, pop_ok);
         if (pop_ok) chk("mix_data", data_out, exp_d);
      end
      for (int i = 0; i < 8 && exp_q.size() < 5; i++) begin
         exp_q.push_back(6'(i));
         cyc(1, 6'(i), 0);
      end
      chk("pre_rst_count", count, 5);

      // Reset with a push in the same cycle: everything discarded.
      @(negedge clk);
      rst     = 1'b1;
      push    = 1'b1;
      data_in = 6'h3e;
      pop     = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_valid", valid_out, 0);
      chk("mid_rst_dout", data_out, 0);
      @(negedge clk);
      rst  = 1'b0;
      push = 1'b0;
      cyc(1, 6'h01, 0);
      chk("post_rst_count", count, 1);
      cyc(0, 6'h00, 1);
      chk("post_rst_data", data_out, 6'h01);
      chk("post_rst_empty", empty, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fifo_umbral
